// File: rtl/irq_priority_encoder_pkg.sv
// Shared definitions for the interrupt request priority encoder:
// line count, code type, reset constants and the output FSM states.
package irq_penc_defs;

  localparam int N = 16;
  localparam int W = $clog2(N);

  typedef logic [W-1:0] code_t;
  typedef enum logic {ST_IDLE, ST_PRESENT} state_e;

  localparam logic [N-1:0] MASK_RST = '0;
  localparam logic [N-1:0] PEND_RST = '0;
  localparam code_t        CODE_RST = '0;

  function automatic logic [N-1:0] code_onehot(input code_t c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_priority_encoder_penc16_comb.sv
// Combinational priority encoder: index of the highest set bit plus an any-set flag.
module penc16_comb
  import irq_penc_defs::*;
(
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/irq_priority_encoder.sv
// 16-line sticky request collector with masked highest-index-first encoding over valid/ready.
// Define IRQ_PENC_EDGE_TRIGGER_EN to capture only rising edges of req instead of levels.
module irq_priority_encoder
  import irq_penc_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mask_wr,
  input  logic [N-1:0] mask_in,
  output logic [N-1:0] mask,
  output logic [N-1:0] pending,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready
);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q, mask_d;
  code_t        code_q, code_d;
  state_e       state_q, state_d;

  logic [N-1:0] cap, clr, eligible;
  code_t        enc_idx;
  logic         enc_any;
  logic         accept;

`ifdef IRQ_PENC_EDGE_TRIGGER_EN
  logic [N-1:0] req_q;

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req;
  end

  assign cap = req & ~req_q;
`else
  assign cap = req;
`endif

  assign accept   = (state_q == ST_PRESENT) && ready;
  assign clr      = accept ? code_onehot(code_q) : '0;
  // The bit being served is excluded so one assertion is never presented twice.
  assign eligible = pending_q & ~mask_q & ~clr;

  penc16_comb u_penc (
    .vec_i (eligible),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    // A new capture on the bit being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | cap;
    mask_d    = mask_wr ? mask_in : mask_q;
    state_d   = state_q;
    code_d    = code_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          state_d = ST_PRESENT;
          code_d  = enc_idx;
        end
      end
      ST_PRESENT: begin
        if (accept) begin
          if (enc_any) code_d  = enc_idx;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= PEND_RST;
      mask_q    <= MASK_RST;
      code_q    <= CODE_RST;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      code_q    <= code_d;
      state_q   <= state_d;
    end
  end

  assign pending = pending_q;
  assign mask    = mask_q;
  assign code    = code_q;
  assign valid   = (state_q == ST_PRESENT);

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Self-checking bench for irq_priority_encoder: directed scenarios plus random traffic
// against a cycle-level reference model of the request/mask/handshake rules.
module tb_irq_priority_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        mask_wr;
  logic [15:0] mask_in;
  logic [15:0] mask;
  logic [15:0] pending;
  logic [3:0]  code;
  logic        valid;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [15:0] m_pend, m_mask, m_reqp;
  logic        m_valid;
  logic [3:0]  m_code;

  irq_priority_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask_wr (mask_wr),
    .mask_in (mask_in),
    .mask    (mask),
    .pending (pending),
    .code    (code),
    .valid   (valid),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    bit          acc;
    bit          np[16];
    int          top;
    logic [15:0] next_reqp;
    acc = m_valid && ready;
    for (int i = 0; i < 16; i++) begin
      bit c;
`ifdef IRQ_PENC_EDGE_TRIGGER_EN
      c = req[i] && !m_reqp[i];
`else
      c = req[i];
`endif
      np[i] = (m_pend[i] && !(acc && i == int'(m_code))) || c;
    end
    top = -1;
    for (int i = 0; i < 16; i++)
      if (m_pend[i] && !m_mask[i] && !(acc && i == int'(m_code))) top = i;
    next_reqp = req;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_reqp = '0; m_valid = 0; m_code = '0;
    end else begin
      if (!m_valid) begin
        if (top >= 0) begin m_valid = 1; m_code = 4'(top); end
      end else if (acc) begin
        if (top >= 0) m_code = 4'(top);
        else          m_valid = 0;
      end
      for (int i = 0; i < 16; i++) m_pend[i] = np[i];
      if (mask_wr) m_mask = mask_in;
      m_reqp = next_reqp;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mask",    32'(mask),    32'(m_mask));
    chk("valid",   32'(valid),   32'(m_valid));
    chk("code",    32'(code),    32'(m_code));
  endtask

  initial begin
    rst = 1; req = 16'hFFFF; mask_wr = 0; mask_in = '0; ready = 0;
    // reset with all requests asserted
    step(); step();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_mask", 32'(mask), 0);
    rst = 0; req = '0;
    step(); step();

    // priority and latency
    ready = 1; req = 16'h0024;
    step();
    chk("lat_pend", 32'(pending), 32'h0024);
    chk("lat_valid0", 32'(valid), 0);
    req = '0;
    step();
    chk("lat_valid1", 32'(valid), 1);
    chk("lat_code5", 32'(code), 5);
    step();
    chk("lat_code2", 32'(code), 2);
    step();
    chk("lat_empty_valid", 32'(valid), 0);
    chk("lat_empty_pend", 32'(pending), 0);

    // stall, no preemption
    ready = 0; req = 16'h0008;
    step();
    req = '0;
    step();
    req = 16'h1000;
    step();
    req = '0;
    step();
    chk("stall_code3", 32'(code), 3);
    chk("stall_valid", 32'(valid), 1);
    ready = 1;
    step();
    chk("stall_code12", 32'(code), 12);
    step();
    chk("stall_idle", 32'(valid), 0);

    // mask
    mask_wr = 1; mask_in = 16'h8000;
    step();
    mask_wr = 0; req = 16'h8001;
    step();
    req = '0;
    step();
    chk("mask_code0", 32'(code), 0);
    chk("mask_valid", 32'(valid), 1);
    step();
    chk("mask_idle", 32'(valid), 0);
    chk("mask_pend", 32'(pending), 32'h8000);
    mask_wr = 1; mask_in = '0;
    step();
    mask_wr = 0;
    step();
    chk("unmask_code15", 32'(code), 15);
    chk("unmask_valid", 32'(valid), 1);
    step();
    step();

    // set-vs-clear collision with req[7] held
    ready = 0; req = 16'h0080;
    step(); step();
    chk("coll_code7", 32'(code), 7);
    ready = 1;
    step();
`ifdef IRQ_PENC_EDGE_TRIGGER_EN
    chk("coll_pend7", 32'(pending[7]), 0);
`else
    chk("coll_pend7", 32'(pending[7]), 1);
`endif
    step();
`ifdef IRQ_PENC_EDGE_TRIGGER_EN
    chk("coll_again", 32'(valid), 0);
`else
    chk("coll_again", 32'(valid), 1);
    chk("coll_again_code", 32'(code), 7);
`endif
    req = '0;
    step(); step(); step();

    // reset in the middle of an accepting transfer
    ready = 0; req = 16'h0030;
    step();
    req = '0;
    step();
    chk("mid_valid", 32'(valid), 1);
    ready = 1; rst = 1;
    step();
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_pend", 32'(pending), 0);
    rst = 0;
    step();
    chk("mid_no_second", 32'(valid), 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      req     = ($urandom_range(0, 3) == 0) ? 16'($urandom) & 16'($urandom) : '0;
      ready   = ($urandom_range(0, 2) != 0);
      mask_wr = ($urandom_range(0, 15) == 0);
      mask_in = 16'($urandom) & 16'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
